regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with a pending-write scoreboard, the successor to the single-write, two-read, combinational-read register file. It sits between decode/issue and writeback in the core. It serves NUM_RD registered read ports and accepts NUM_WR writeback ports per cycle. It tracks which registers have an outstanding long-latency writeback so that issue can stall on RAW hazards. x0 is hardwired to zero and is never marked busy.

## Interface
- DATA_WIDTH, 32, register width in bits
- REG_COUNT, 32, number of architectural registers (power of two, ≥2); ADDR_W = $clog2(REG_COUNT)
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports (higher index has priority)

Clock and reset: one clock, `clk`; reset is asynchronous and active-low, `rst_n`.

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  NUM_RD  per-port read capture enable
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port j at [j*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_WIDTH  registered read data, port j at [j*DATA_WIDTH +: DATA_WIDTH]
- rd_busy  out  NUM_RD  registered scoreboard bit of the captured address
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_WIDTH  write data
- rsv_en  in  1  reserve a destination (mark busy) for a newly issued instruction
- rsv_addr  in  ADDR_W  register to reserve
- rsv_conflict  out  1  combinational; reservation refused this cycle
- busy  out  REG_COUNT  scoreboard vector, registered; busy[0] is constant 0

## Operation
- Reset (async assert, sync release): all registers 0, busy all 0, rd_data 0, rd_busy 0. Asserting reset mid-operation discards in-flight writes, reservations and reads immediately.
- Write: for each i with wr_en[i]=1 and wr_addr[i]≠0, the register is updated at the edge. If several ports target the same address, the highest index wins. Writes to x0 are ignored.
- Scoreboard clear: any enabled write to address a≠0 clears busy[a] at the edge.
- Reservation: rsv_en=1 with rsv_addr≠0 sets busy[rsv_addr].
- rsv_conflict = rsv_en & (rsv_addr≠0) & busy[rsv_addr] & ~(any enabled write to rsv_addr this cycle). On conflict the scoreboard is unchanged and the issuer must hold the instruction.
- A reservation to an address being written in the same cycle is accepted, and busy ends at 1 because set beats clear.
- rsv_en with rsv_addr=0 is a no-op and never conflicts.
- Read: when rd_en[j]=1, rd_data[j] and rd_busy[j] capture the value for rd_addr[j] at the edge. When rd_en[j]=0 both hold their previous value. Address 0 always returns 0 and busy 0.
- Read/write ordering (same edge, same address) is governed by REGFILE_BYPASS_EN (see Configuration).
- No state machine beyond the per-register busy flags. Data and busy are flop arrays; no memory macro.

## Timing
- Read latency: 1 cycle (address at edge N, data valid after edge N, usable in cycle N+1).
- Write latency: the register holds the new value after the edge.
- busy updates at the same edge as the write or reservation. rsv_conflict is purely combinational from current busy, rsv_* and wr_*.
- Unlimited same-address reads per cycle. All NUM_RD ports are independent.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read capturing address a in the same cycle as an enabled write to a (a≠0) returns the winning write's wr_data.
  - rd_busy returns the post-edge busy value, i.e. the reserve/clear result of that same edge.
- REGFILE_BYPASS_EN undefined:
  - Same-cycle read returns the pre-write register contents.
  - rd_busy returns pre-edge busy. Issue must allow one extra cycle after writeback.

## Test plan
- Reset then read all REG_COUNT addresses on every port -> every rd_data = 0, rd_busy = 0, busy = 0.
- Write x5=0xDEADBEEF via port 0, next cycle read x5 on port 1 -> rd_data[1]=0xDEADBEEF; write x0=0x1234 then read x0 -> 0.
- Same cycle: wr port 0 x7=0x11, wr port 1 x7=0x22 -> x7 reads 0x22.
- rsv x9; next cycle rsv x9 again -> rsv_conflict=1, busy[9] stays 1. Write x9=0x5 -> busy[9]=0. In a separate sequence, rsv x9 in the same cycle as a write to x9 -> rsv_conflict=0, busy[9]=1.
- Same-edge write x3=0xAA with read x3 (old value 0x0) -> with REGFILE_BYPASS_EN rd_data=0xAA; without it rd_data=0x0.
- Assert rst_n low mid-cycle while busy[4]=1 and rd_data nonzero -> busy and rd_data go 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundle of read, writeback and reservation signals of the
// multi-port register file. The issue/writeback side uses the master modport,
// the register file itself uses the slave modport.
interface regfile_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
);
  localparam int ADDR_W = $clog2(REG_COUNT);

  logic [NUM_RD-1:0]            rd_en;
  logic [NUM_RD*ADDR_W-1:0]     rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_busy;
  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR*ADDR_W-1:0]     wr_addr;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
  logic                         rsv_en;
  logic [ADDR_W-1:0]            rsv_addr;
  logic                         rsv_conflict;
  logic [REG_COUNT-1:0]         busy;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_conflict, busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_conflict, busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a pending-write
// scoreboard. NUM_RD registered read ports, NUM_WR writeback ports (higher
// port index wins on an address collision), one reservation port that marks a
// destination busy. x0 reads as zero and is never busy.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read that
// captures the address being written on the same edge sees the new data and
// the post-edge busy flag; otherwise it sees the pre-edge contents.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);
  localparam int ADDR_W = $clog2(REG_COUNT);

  logic [DATA_WIDTH-1:0] mem      [REG_COUNT];
  logic [DATA_WIDTH-1:0] wr_val   [REG_COUNT];
  logic [REG_COUNT-1:0]  wr_hit;
  logic [REG_COUNT-1:0]  sb;
  logic [REG_COUNT-1:0]  sb_next;
  logic [REG_COUNT-1:0]  rsv_vec;
  logic                  rsv_hit;
  logic                  conflict;
  logic [ADDR_W-1:0]     rd_a     [NUM_RD];
  logic [DATA_WIDTH-1:0] rd_word  [NUM_RD];
  logic                  rd_flag  [NUM_RD];

  // Per-register write decode; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    wr_hit = {REG_COUNT{1'b0}};
    for (int k = 0; k < REG_COUNT; k++) begin
      wr_val[k] = {DATA_WIDTH{1'b0}};
    end
    for (int k = 1; k < REG_COUNT; k++) begin
      for (int i = 0; i < NUM_WR; i++) begin
        wr_hit[k] = wr_hit[k] |
                    (bus.wr_en[i] && (bus.wr_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(k)));
        wr_val[k] = (bus.wr_en[i] && (bus.wr_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(k)))
                    ? bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH] : wr_val[k];
      end
    end
  end

  // Scoreboard next state: writes clear, an accepted reservation sets (set beats clear).
  always_comb begin
    rsv_hit  = bus.rsv_en && (bus.rsv_addr != {ADDR_W{1'b0}});
    conflict = rsv_hit && sb[bus.rsv_addr] && !wr_hit[bus.rsv_addr];
    rsv_vec  = (rsv_hit && !conflict) ? (REG_COUNT'(1) << bus.rsv_addr)
                                      : {REG_COUNT{1'b0}};
    sb_next  = ((sb & ~wr_hit) | rsv_vec) & {{(REG_COUNT-1){1'b1}}, 1'b0};
  end

  // Read-port source selection: bypassed or pre-edge view of data and busy.
  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      rd_a[j] = bus.rd_addr[j*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      rd_word[j] = wr_hit[rd_a[j]] ? wr_val[rd_a[j]] : mem[rd_a[j]];
      rd_flag[j] = sb_next[rd_a[j]];
`else
      rd_word[j] = mem[rd_a[j]];
      rd_flag[j] = sb[rd_a[j]];
`endif
    end
  end

  // Register array and scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < REG_COUNT; k++) begin
        mem[k] <= {DATA_WIDTH{1'b0}};
      end
      sb <= {REG_COUNT{1'b0}};
    end else begin
      for (int k = 0; k < REG_COUNT; k++) begin
        if (wr_hit[k]) begin
          mem[k] <= wr_val[k];
        end else begin
          mem[k] <= mem[k];
        end
      end
      sb <= sb_next;
    end
  end

  // Registered read ports; a disabled port holds its last captured value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_data <= {(NUM_RD*DATA_WIDTH){1'b0}};
      bus.rd_busy <= {NUM_RD{1'b0}};
    end else begin
      for (int j = 0; j < NUM_RD; j++) begin
        if (bus.rd_en[j]) begin
          bus.rd_data[j*DATA_WIDTH +: DATA_WIDTH] <= rd_word[j];
          bus.rd_busy[j]                          <= rd_flag[j];
        end else begin
          bus.rd_data[j*DATA_WIDTH +: DATA_WIDTH] <= bus.rd_data[j*DATA_WIDTH +: DATA_WIDTH];
          bus.rd_busy[j]                          <= bus.rd_busy[j];
        end
      end
    end
  end

  assign bus.busy         = sb;
  assign bus.rsv_conflict = conflict;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed stimulus for regfile_mp, checked
// against an array-based reference model of the register file and scoreboard.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int RC = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;

  logic clk;
  logic rst_n;

  regfile_mp_if #(.DATA_WIDTH(DW), .REG_COUNT(RC), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  regfile_mp #(.DATA_WIDTH(DW), .REG_COUNT(RC), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DW-1:0] m_reg [RC];
  logic [RC-1:0] m_busy;
  logic [DW-1:0] m_rd  [NR];
  logic          m_rdb [NR];

  // stimulus for the next cycle
  logic          t_rd_en   [NR];
  logic [AW-1:0] t_rd_addr [NR];
  logic          t_wr_en   [NW];
  logic [AW-1:0] t_wr_addr [NW];
  logic [DW-1:0] t_wr_data [NW];
  logic          t_rsv_en;
  logic [AW-1:0] t_rsv_addr;
  logic          conf_seen;

  // free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < RC; k++) m_reg[k] = 32'd0;
    m_busy = 32'd0;
    for (int j = 0; j < NR; j++) begin
      m_rd[j]  = 32'd0;
      m_rdb[j] = 1'b0;
    end
  endtask

  task automatic idle();
    for (int j = 0; j < NR; j++) begin
      t_rd_en[j]   = 1'b0;
      t_rd_addr[j] = 5'd0;
    end
    for (int i = 0; i < NW; i++) begin
      t_wr_en[i]   = 1'b0;
      t_wr_addr[i] = 5'd0;
      t_wr_data[i] = 32'd0;
    end
    t_rsv_en   = 1'b0;
    t_rsv_addr = 5'd0;
  endtask

  task automatic drive();
    for (int j = 0; j < NR; j++) begin
      bus.rd_en[j]             = t_rd_en[j];
      bus.rd_addr[j*AW +: AW]  = t_rd_addr[j];
    end
    for (int i = 0; i < NW; i++) begin
      bus.wr_en[i]             = t_wr_en[i];
      bus.wr_addr[i*AW +: AW]  = t_wr_addr[i];
      bus.wr_data[i*DW +: DW]  = t_wr_data[i];
    end
    bus.rsv_en   = t_rsv_en;
    bus.rsv_addr = t_rsv_addr;
  endtask

  // One clock cycle: apply stimulus, predict, check conflict before the edge and state after it.
  task automatic step();
    logic [DW-1:0] nreg [RC];
    logic [RC-1:0] written;
    logic [RC-1:0] nbusy;
    logic          exp_conf;
    drive();
    nreg    = m_reg;
    written = 32'd0;
    for (int i = 0; i < NW; i++) begin
      if (t_wr_en[i] && t_wr_addr[i] != 5'd0) begin
        nreg[t_wr_addr[i]]    = t_wr_data[i];
        written[t_wr_addr[i]] = 1'b1;
      end
    end
    exp_conf = t_rsv_en && (t_rsv_addr != 5'd0) && m_busy[t_rsv_addr] && !written[t_rsv_addr];
    nbusy = m_busy & ~written;
    if (t_rsv_en && t_rsv_addr != 5'd0 && !exp_conf) nbusy[t_rsv_addr] = 1'b1;
    for (int j = 0; j < NR; j++) begin
      if (t_rd_en[j]) begin
`ifdef REGFILE_BYPASS_EN
        m_rd[j]  = nreg[t_rd_addr[j]];
        m_rdb[j] = nbusy[t_rd_addr[j]];
`else
        m_rd[j]  = m_reg[t_rd_addr[j]];
        m_rdb[j] = m_busy[t_rd_addr[j]];
`endif
      end
    end
    #1;
    conf_seen = bus.rsv_conflict;
    check("rsv_conflict", 64'(bus.rsv_conflict), 64'(exp_conf));
    @(posedge clk);
    m_reg  = nreg;
    m_busy = nbusy;
    #1;
    for (int j = 0; j < NR; j++) begin
      check($sformatf("rd_data%0d", j), 64'(bus.rd_data[j*DW +: DW]), 64'(m_rd[j]));
      check($sformatf("rd_busy%0d", j), 64'(bus.rd_busy[j]), 64'(m_rdb[j]));
    end
    check("busy", 64'(bus.busy), 64'(m_busy));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    drive();
    model_reset();
    conf_seen = 1'b0;
    #12 rst_n = 1'b1;

    check("reset_busy", 64'(bus.busy), 64'h0);
    check("reset_rd_data", 64'(bus.rd_data), 64'h0);
    check("reset_rd_busy", 64'(bus.rd_busy), 64'h0);

    // read every address on every port after reset
    for (int a = 0; a < RC; a++) begin
      idle();
      for (int j = 0; j < NR; j++) begin
        t_rd_en[j]   = 1'b1;
        t_rd_addr[j] = AW'(a);
      end
      step();
      check("reset_read_all", 64'(bus.rd_data), 64'h0);
    end

    // write x5 via port 0, read on port 1
    idle(); t_wr_en[0] = 1'b1; t_wr_addr[0] = 5'd5; t_wr_data[0] = 32'hDEADBEEF; step();
    idle(); t_rd_en[1] = 1'b1; t_rd_addr[1] = 5'd5; step();
    check("x5_port1", 64'(bus.rd_data[63:32]), 64'hDEADBEEF);

    // writes to x0 are dropped
    idle(); t_wr_en[0] = 1'b1; t_wr_addr[0] = 5'd0; t_wr_data[0] = 32'h1234; step();
    idle(); t_rd_en[0] = 1'b1; t_rd_addr[0] = 5'd0; step();
    check("x0_read", 64'(bus.rd_data[31:0]), 64'h0);

    // same-address write collision: port 1 wins
    idle();
    t_wr_en[0] = 1'b1; t_wr_addr[0] = 5'd7; t_wr_data[0] = 32'h11;
    t_wr_en[1] = 1'b1; t_wr_addr[1] = 5'd7; t_wr_data[1] = 32'h22;
    step();
    idle(); t_rd_en[0] = 1'b1; t_rd_addr[0] = 5'd7; step();
    check("x7_priority", 64'(bus.rd_data[31:0]), 64'h22);

    // reservation, conflict and clear
    idle(); t_rsv_en = 1'b1; t_rsv_addr = 5'd9; step();
    check("busy9_set", 64'(bus.busy[9]), 64'h1);
    idle(); t_rsv_en = 1'b1; t_rsv_addr = 5'd9; step();
    check("rsv9_conflict", 64'(conf_seen), 64'h1);
    check("busy9_hold", 64'(bus.busy[9]), 64'h1);
    idle(); t_wr_en[0] = 1'b1; t_wr_addr[0] = 5'd9; t_wr_data[0] = 32'h5; step();
    check("busy9_clear", 64'(bus.busy[9]), 64'h0);

    // reservation together with a write to the same register is accepted
    idle(); t_rsv_en = 1'b1; t_rsv_addr = 5'd9; step();
    idle();
    t_rsv_en = 1'b1; t_rsv_addr = 5'd9;
    t_wr_en[1] = 1'b1; t_wr_addr[1] = 5'd9; t_wr_data[1] = 32'h77;
    step();
    check("rsv9_wr_noconf", 64'(conf_seen), 64'h0);
    check("rsv9_wr_busy", 64'(bus.busy[9]), 64'h1);

    // reservation of x0 is a no-op
    idle(); t_rsv_en = 1'b1; t_rsv_addr = 5'd0; step();
    check("rsv0_noop", 64'(bus.busy[0]), 64'h0);

    // same-edge write and read of x3
    idle();
    t_wr_en[0] = 1'b1; t_wr_addr[0] = 5'd3; t_wr_data[0] = 32'hAA;
    t_rd_en[0] = 1'b1; t_rd_addr[0] = 5'd3;
    step();
`ifdef REGFILE_BYPASS_EN
    check("same_edge_x3", 64'(bus.rd_data[31:0]), 64'hAA);
`else
    check("same_edge_x3", 64'(bus.rd_data[31:0]), 64'h0);
`endif

    // randomized traffic concentrated on a few registers to force collisions
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int j = 0; j < NR; j++) begin
        t_rd_en[j]   = 1'($urandom_range(0, 1));
        t_rd_addr[j] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31))
                                                   : AW'($urandom_range(0, 7));
      end
      for (int i = 0; i < NW; i++) begin
        t_wr_en[i]   = 1'($urandom_range(0, 1));
        t_wr_addr[i] = AW'($urandom_range(0, 7));
        t_wr_data[i] = $urandom();
      end
      t_rsv_en   = 1'($urandom_range(0, 1));
      t_rsv_addr = AW'($urandom_range(0, 7));
      step();
    end

    // asynchronous reset in the middle of a cycle
    idle();
    t_wr_en[0] = 1'b1; t_wr_addr[0] = 5'd2; t_wr_data[0] = 32'hCAFE0001;
    t_rsv_en = 1'b1; t_rsv_addr = 5'd4;
    step();
    idle(); t_rd_en[0] = 1'b1; t_rd_addr[0] = 5'd2; t_rd_en[1] = 1'b1; t_rd_addr[1] = 5'd2; step();
    check("pre_rst_busy4", 64'(bus.busy[4]), 64'h1);
    check("pre_rst_rd_nonzero", 64'(bus.rd_data != 64'h0), 64'h1);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'h0);
    check("async_rst_rd_data", 64'(bus.rd_data), 64'h0);
    check("async_rst_rd_busy", 64'(bus.rd_busy), 64'h0);
    #2 rst_n = 1'b1;
    idle(); t_rd_en[0] = 1'b1; t_rd_addr[0] = 5'd2; step();
    check("post_rst_x2", 64'(bus.rd_data[31:0]), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
